// File: rtl/mw_add_seq.sv
// ---------------------------------------------------------------------------
// mw_add_seq
//
// Multi-word add/subtract sequencer. Two WORDS x 8-bit operands are accepted
// over a valid/ready handshake and summed one byte per cycle, LSB byte first.
// Each byte goes through a single 8-bit carry-lookahead slice, and the carry
// is registered between bytes. The full-width result and carry-out are then
// presented on a valid/ready output handshake.
//
// Optional feature (macro MWADD_OVF_EN):
//   When defined, adds output port ovf, the signed two's-complement overflow
//   of the full-width operation. It is captured together with c_out.
//   When undefined, the port and its logic are absent.
//
// Parameters:
//   WORDS      bytes per operand (2..16); operand width W = 8*WORDS
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block can accept an operand set (registered)
//   op_a       operand A (W bits)
//   op_b       operand B (W bits)
//   sub        0: A+B+c_in, 1: A-B (B inverted, carry-in forced to 1)
//   c_in       carry-in, add mode only
//   out_valid  result valid (registered)
//   out_ready  downstream accepts result
//   sum        result (W bits), held stable while waiting for out_ready
//   c_out      carry out of MSB byte; in subtract mode 1 = no borrow
//   busy       high while running or holding a result
//   ovf        signed overflow (only with MWADD_OVF_EN)
// ---------------------------------------------------------------------------
module mw_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               sub,
  input  logic               c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               c_out,
  output logic               busy
`ifdef MWADD_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int W    = 8 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [7:0]      aByte;
  logic [7:0]      bByte;
  logic [7:0]      gen;
  logic [7:0]      prop;
  logic [8:0]      carryVec;
  logic            lookRun;
  logic [7:0]      sumByte_d;
  logic            carry_d;
`ifdef MWADD_OVF_EN
  logic            ovf_q;
  logic            ovf_d;
`endif

  // The byte slice. Every internal carry is formed in lookahead form, as the
  // OR of each lower generate term ANDed with the propagates above it, plus
  // the registered carry ANDed with every propagate below the bit. The slice
  // reads the byte selected by idx_q; its result only matters during RUN.
  always_comb begin
    aByte       = a_q[8*idx_q +: 8];
    bByte       = b_q[8*idx_q +: 8];
    gen         = aByte & bByte;
    prop        = aByte ^ bByte;
    carryVec    = '0;
    carryVec[0] = carry_q;
    lookRun     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      carryVec[i+1] = gen[i];
      lookRun       = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carryVec[i+1] = carryVec[i+1] | (lookRun & gen[j]);
        lookRun       = lookRun & prop[j];
      end
      carryVec[i+1] = carryVec[i+1] | (lookRun & carry_q);
    end
    sumByte_d = prop ^ carryVec[7:0];
    carry_d   = carryVec[8];
`ifdef MWADD_OVF_EN
    // On the last byte, the carries into and out of bit 7 are the carries
    // into and out of the full-width MSB.
    ovf_d     = carryVec[7] ^ carryVec[8];
`endif
  end

  // Sequencer FSM. Every handshake output is a register, so nothing passes
  // combinationally from the inputs to the outputs. As a result, in_ready
  // rises only in the cycle after the result is taken. Subtraction is handled
  // at capture time: B is stored inverted and the carry is preset to 1, so the
  // RUN loop only ever adds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MWADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= op_a;
            b_q        <= sub ? ~op_b : op_b;
            carry_q    <= sub ? 1'b1 : c_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[8*idx_q +: 8] <= sumByte_d;
          carry_q             <= carry_d;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q      <= carry_d;
`ifdef MWADD_OVF_EN
            ovf_q       <= ovf_d;
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign busy      = busy_q;
`ifdef MWADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mw_add_seq.sv
// ---------------------------------------------------------------------------
// tb_mw_add_seq
//
// Testbench for mw_add_seq with WORDS=4. Directed scenarios push their
// required results into a scoreboard queue when the operands are driven.
// Random operations push results from an integer model. Each scenario task
// pops the expected entry when the DUT presents a result, then compares it.
// Inputs are driven and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mw_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;
  localparam int LIMIT = 50;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef MWADD_OVF_EN
  logic         ovf;
`endif

  exp_t sbQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  mw_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef MWADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Integer reference model of the full-width operation.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic ci);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   t;
    bb  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Drives one operand set. It waits (bounded) for in_ready, holds in_valid
  // over one rising edge, then returns on the falling edge after the accept.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input logic ci,
                               input exp_t e, input bit push);
    int waitCount;
    waitCount = 0;
    while (!in_ready && waitCount < LIMIT) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitCount);
    end
    op_a     = a;
    op_b     = b;
    sub      = s;
    c_in     = ci;
    in_valid = 1'b1;
    if (push) sbQ.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, captures the outputs, then takes the
  // result with a one-cycle out_ready pulse.
  task automatic getResult(output logic [W-1:0] s, output logic c,
                           output logic o, output bit ok);
    int waitCount;
    waitCount = 0;
    while (!out_valid && waitCount < LIMIT) begin
      @(negedge clk);
      waitCount++;
    end
    ok = out_valid;
    s  = sum;
    c  = c_out;
`ifdef MWADD_OVF_EN
    o  = ovf;
`else
    o  = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    c_in      = 1'b0;
    repeat (2) @(negedge clk);
    assertCount++;
    if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready); end
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b, required 0", busy); end
    assertCount++;
    if (sum !== '0 || c_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_sum: got %h/%0b, required 0/0", sum, c_out); end
`ifdef MWADD_OVF_EN
    assertCount++;
    if (ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %0b, required 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Also checks the latency: out_valid is seen 4 cycles after the accept edge.
  task automatic test_add_wrap();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    int           cycles;
    e = '{s: 32'h0000_0000, c: 1'b1, o: 1'b0};
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e, 1'b1);
    assertCount++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL run_flags: busy=%0b in_ready=%0b, required 1/0", busy, in_ready); end
    cycles = 0;
    while (!out_valid && cycles < LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    assertCount++;
    if (cycles != 4) begin failCount++; $display("[TB] FAIL latency: got %0d cycles, required 4", cycles); end
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL add_wrap: got %h/%0b ok=%0b, required %h/%0b", s, c, ok, e.s, e.c); end
  endtask

  task automatic test_sub();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, '{s: 32'hFFFF_FFFE, c: 1'b0, o: 1'b0}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL sub_borrow: got %h/%0b, required %h/%0b", s, c, e.s, e.c); end
    applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, '{s: 32'h0000_0002, c: 1'b1, o: 1'b0}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL sub_noborrow: got %h/%0b, required %h/%0b", s, c, e.s, e.c); end
  endtask

  // Holds out_ready low for 10 cycles while new operands are waved at the
  // input. The result must stay put and in_ready must stay low throughout.
  task automatic test_backpressure();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    int           waitCount;
    int           badCycles;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, '{s: 32'h2345_678A, c: 1'b0, o: 1'b0}, 1'b1);
    e        = sbQ.pop_front();
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'hCAFE_F00D;
    in_valid = 1'b1;
    waitCount = 0;
    while (!out_valid && waitCount < LIMIT) begin
      @(negedge clk);
      waitCount++;
    end
    badCycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (sum !== e.s || c_out !== e.c || in_ready !== 1'b0 || out_valid !== 1'b1) badCycles++;
      @(negedge clk);
    end
    assertCount++;
    if (badCycles != 0) begin failCount++; $display("[TB] FAIL hold_stable: %0d bad cycles, required 0 (sum=%h)", badCycles, sum); end
    in_valid = 1'b0;
    getResult(s, c, o, ok);
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL backpressure_result: got %h/%0b, required %h/%0b", s, c, e.s, e.c); end
    assertCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL handoff: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_op();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    assertCount++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL abort_flags: out_valid=%0b in_ready=%0b busy=%0b, required 0/1/0", out_valid, in_ready, busy); end
    assertCount++;
    if (sum !== '0 || c_out !== 1'b0) begin failCount++; $display("[TB] FAIL abort_sum: got %h/%0b, required 0/0", sum, c_out); end
    repeat (6) @(negedge clk);
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL abort_no_result: out_valid=%0b, required 0", out_valid); end
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, '{s: 32'h0000_0003, c: 1'b0, o: 1'b0}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL after_reset: got %h/%0b, required %h/%0b", s, c, e.s, e.c); end
  endtask

  task automatic test_carry_chain();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    applyStimulus(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, '{s: 32'h0100_0100, c: 1'b0, o: 1'b0}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c) begin failCount++; $display("[TB] FAIL carry_chain: got %h/%0b, required %h/%0b", s, c, e.s, e.c); end
  endtask

  task automatic test_random();
    exp_t         e;
    logic [W-1:0] a, b, s;
    logic         sb, ci, c, o;
    bit           ok;
    int           errs;
    errs = 0;
    for (int n = 0; n < 1000; n++) begin
      a  = $urandom();
      b  = $urandom();
      sb = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      applyStimulus(a, b, sb, ci, model(a, b, sb, ci), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      getResult(s, c, o, ok);
      e = sbQ.pop_front();
      assertCount++;
      if (!ok || s !== e.s || c !== e.c) begin
        failCount++;
        errs++;
        if (errs <= 10) $display("[TB] FAIL random_op: a=%h b=%h sub=%0b c_in=%0b got %h/%0b, required %h/%0b", a, b, sb, ci, s, c, e.s, e.c);
      end
`ifdef MWADD_OVF_EN
      assertCount++;
      if (o !== e.o) begin failCount++; $display("[TB] FAIL random_ovf: got %0b, required %0b", o, e.o); end
`endif
    end
  endtask

`ifdef MWADD_OVF_EN
  task automatic test_ovf();
    exp_t         e;
    logic [W-1:0] s;
    logic         c, o;
    bit           ok;
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{s: 32'h8000_0000, c: 1'b0, o: 1'b1}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c || o !== e.o) begin failCount++; $display("[TB] FAIL ovf_add: got %h/%0b/%0b, required %h/%0b/%0b", s, c, o, e.s, e.c, e.o); end
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, '{s: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1}, 1'b1);
    getResult(s, c, o, ok);
    e = sbQ.pop_front();
    assertCount++;
    if (!ok || s !== e.s || c !== e.c || o !== e.o) begin failCount++; $display("[TB] FAIL ovf_sub: got %h/%0b/%0b, required %h/%0b/%0b", s, c, o, e.s, e.c, e.o); end
  endtask
`endif

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_backpressure();
    test_reset_mid_op();
    test_carry_chain();
`ifdef MWADD_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mw_add_seq.md
Name: mw_add_seq

Overview:
- Multi-word add/subtract sequencer.
- Accepts two WORDS×8-bit operands over a valid/ready handshake and adds them one byte per cycle through an internal 8-bit carry-lookahead slice, LSB byte first, with the carry registered between bytes.
- Sits directly upstream of and around the 8-bit adder datapath, letting the byte-wide adder serve wide arithmetic in the accumulator/ALU path.
- Returns the full-width result and carry-out on a valid/ready output handshake.

Parameters:
- WORDS, 4, number of 8-bit bytes per operand (legal 2..16); operand width W = 8*WORDS.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  Operand set valid.
- in_ready  output  1  Block can accept an operand set.
- op_a  input  W  Operand A.
- op_b  input  W  Operand B.
- sub  input  1  0 = A+B+c_in; 1 = A-B (B inverted, carry-in forced to 1, c_in ignored).
- c_in  input  1  Carry-in for add mode.
- out_valid  output  1  Result valid.
- out_ready  input  1  Downstream accepts result.
- sum  output  W  Result.
- c_out  output  1  Carry out of MSB byte; in subtract mode 1 = no borrow.
- busy  output  1  High in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; in_ready=1; out_valid=0; busy=0; sum=0; c_out=0.
  - Byte index, carry register and operand registers clear.
  - Reset mid-RUN or in DONE aborts the operation silently; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
    - Capture op_a, (sub ? ~op_b : op_b), and carry = sub ? 1 : c_in.
    - Clear index; go to RUN.
  - RUN: in_ready=0. Each cycle, the slice adds byte[idx] of A and B plus carry.
    - Result byte written to sum[8*idx+:8]; carry register updated with the true slice carry-out; idx increments.
    - After byte WORDS-1: c_out gets the final carry; go to DONE.
  - DONE: out_valid=1. sum and c_out are held stable while out_valid=1 && out_ready=0.
    - On out_ready=1: go to IDLE and drop out_valid.
- Latency:
  - Accept edge E0; bytes computed at edges E1..EWORDS; out_valid high after edge EWORDS.
  - For WORDS=4, out_valid is seen in the 4th cycle after the accept cycle.
- Throughput: one operation per WORDS+2 cycles minimum. No accept in the DONE→IDLE handoff cycle (in_ready is registered, no combinational in/out bypass).
- Slice arithmetic is exact 8-bit: {cout, s} = a + b + cin. Full result must equal the integer (A + B' + cin) mod 2^W, with c_out = bit W.
- Input changes while not in IDLE are ignored; in_valid held high during RUN/DONE is not accepted until IDLE.
- sum keeps its last value in IDLE. Its contents are undefined-free (deterministic) but only meaningful while out_valid=1.

Optional Feature:
- Macro: MWADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), the signed two's-complement overflow of the full-width op.
  - ovf = carry into MSB bit XOR carry out of MSB bit, captured with c_out.
  - Reset 0; held with sum in DONE.
- Undefined: port ovf absent; no overflow logic.

Test Plan:
- WORDS=4, add, A=0xFFFFFFFF, B=0x00000001, c_in=0 -> sum=0x00000000, c_out=1; out_valid rises 4 cycles after accept edge.
- WORDS=4, sub, A=0x00000005, B=0x00000007 -> sum=0xFFFFFFFE, c_out=0. Then A=0x00000007, B=0x00000005 -> sum=0x00000002, c_out=1.
- Backpressure: out_ready=0 for 10 cycles with A=0x12345678, B=0x11111111, c_in=1 -> sum=0x2345678A held stable, in_ready=0 throughout. Completes on out_ready=1; in_ready=1 on the next cycle.
- Reset mid-op: rst_n=0 at RUN byte 2 -> next cycle IDLE, out_valid=0, sum=0, c_out=0. A new op A=1, B=2 then yields sum=3, c_out=0.
- Carry chain through every bit of the slice: A=0x00FF00FF, B=0x00010001 -> sum=0x01000100, c_out=0. Random 1000 ops compared against an integer model.
- With MWADD_OVF_EN: A=0x7FFFFFFF, B=0x00000001 add -> ovf=1, c_out=0. A=0x80000000, B=0x00000001 sub -> ovf=1, sum=0x7FFFFFFF.
